gtx_tx_arb: RTL and testbench



---
 rtl/gtx_pkg.sv | 29 ++
 rtl/rr_arb.sv | 31 +++
 rtl/gtx_tx_arb.sv | 140 ++++++++++++++
 tb/tb_gtx_tx_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtx_pkg.sv
// Shared constants and types for the GTX TX lane scheduler: 8b/10b K-characters,
// the comma idle word, txcharisk encodings and the framing state machine states.
package gtx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;  // comma
  localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
  localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
  localparam logic [7:0] D16_2 = 8'h50;  // idle filler data byte

  localparam logic [15:0] IDLE_WORD = {D16_2, K28_5};

  localparam logic [1:0] CTRL_K_LO = 2'b01;  // low byte is a K-character
  localparam logic [1:0] CTRL_DATA = 2'b00;  // both bytes are data

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_EOF
  } state_t;

  function automatic logic [15:0] sof_word(input logic [7:0] id);
    return {id, K27_7};
  endfunction

  function automatic logic [15:0] eof_word(input logic last, input logic [6:0] cnt);
    return {last, cnt, K29_7};
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: returns the first requester with valid set,
// searching upward from the pointer and wrapping at N_REQ-1 (works for any N_REQ).
module rr_arb #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  // Rotate the request vector so the pointer sits at bit 0, take the lowest set
  // bit as an offset, then map the offset back to an absolute index mod N_REQ.
  always_comb begin
    rot       = N_REQ'({req, req} >> ptr);
    off       = '0;
    any_valid = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    grant = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/gtx_tx_arb.sv
// Round-robin scheduler sharing one 16-bit GTX TX lane between N_REQ streaming
// requesters. Bursts are framed with SOF/EOF K-words, stalls and gaps are filled
// with comma idles, and at least MIN_IDLE idles separate EOF from the next SOF.
module gtx_tx_arb
  import gtx_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_LEN  = 16,
  parameter int MIN_IDLE = 2,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*16-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_last_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [15:0]         data_o,
  output logic [1:0]          ctrl_o,
  output logic [IDX_W-1:0]    grant_o,
  output logic                busy_o
);

  localparam int GAP_W = $clog2(MIN_IDLE + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             last_q, last_d;
  logic [15:0]      data_q, data_d;
  logic [1:0]       ctrl_q, ctrl_d;

  logic [IDX_W-1:0] win;
  logic             any_valid;
  logic [15:0]      cur_data;
  logic             cur_valid;
  logic             cur_last;
  logic [IDX_W:0]   ptr_inc;

  rr_arb #(
    .N_REQ(N_REQ)
  ) u_rr_arb (
    .req      (req_valid_i),
    .ptr      (ptr_q),
    .grant    (win),
    .any_valid(any_valid)
  );

  // Select the granted requester's stream and raise its ready while in a frame.
  always_comb begin
    cur_data    = '0;
    cur_valid   = 1'b0;
    cur_last    = 1'b0;
    req_ready_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q == IDX_W'(k)) begin
        cur_data       = req_data_i[16*k +: 16];
        cur_valid      = req_valid_i[k];
        cur_last       = req_last_i[k];
        req_ready_o[k] = (state_q == ST_DATA);
      end
    end
  end

  // Framing FSM: next state, next lane word and bookkeeping for pointer/gap/count.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    data_d  = IDLE_WORD;
    ctrl_d  = CTRL_K_LO;
    ptr_inc = {1'b0, grant_q} + 1'b1;
    if (ptr_inc == (IDX_W + 1)'(N_REQ)) ptr_inc = '0;

    case (state_q)
      ST_IDLE: begin
        if (gap_q < GAP_W'(MIN_IDLE)) gap_d = gap_q + 1'b1;
        if ((gap_q >= GAP_W'(MIN_IDLE)) && any_valid) begin
          grant_d = win;
          data_d  = sof_word(8'(win));
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // A stalled requester gets idle fill; the frame only ends on last or MAX_LEN.
        if (cur_valid) begin
          data_d = cur_data;
          ctrl_d = CTRL_DATA;
          cnt_d  = cnt_q + 7'd1;
          if (cur_last || (cnt_q + 7'd1 == 7'(MAX_LEN))) begin
            last_d  = cur_last;
            state_d = ST_EOF;
          end
        end
      end
      ST_EOF: begin
        data_d  = eof_word(last_q, cnt_q);
        ptr_d   = ptr_inc[IDX_W-1:0];
        gap_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered lane outputs; reset drops straight back to comma idles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= GAP_W'(MIN_IDLE);
      last_q  <= 1'b0;
      data_q  <= IDLE_WORD;
      ctrl_q  <= CTRL_K_LO;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gtx_tx_arb.sv
// Bench for gtx_tx_arb: per-requester word queues drive the inputs, an expected
// lane-word scoreboard is filled by each scenario and drained by a lane monitor.
module tb_gtx_tx_arb;

  localparam int N_REQ    = 4;
  localparam int MAX_LEN  = 16;
  localparam int MIN_IDLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [15:0] data;
  logic [1:0]  ctrl;
  logic [1:0]  grant;
  logic        busy;

  gtx_tx_arb #(
    .N_REQ(N_REQ),
    .MAX_LEN(MAX_LEN),
    .MIN_IDLE(MIN_IDLE)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .data_o     (data),
    .ctrl_o     (ctrl),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [16:0] rq [4][$];   // {last, word} per requester
  logic [17:0] exp_q [$];   // {ctrl, data} expected non-idle lane words
  int          gap_q [$];   // idle run observed between EOF and following SOF
  logic [3:0]  hold = '0;   // force a requester's valid low

  bit in_frame = 0;
  bit have_eof = 0;
  int gap_run = 0;
  int fill_cnt = 0;
  int last_fill = 0;
  int fr_pay = 0;

  // Requester driver: pops accepted words, presents the head of each queue.
  initial begin
    logic [3:0]  fire;
    logic [16:0] dummy;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (fire[k] && rq[k].size() > 0) dummy = rq[k].pop_front();
        if (rq[k].size() > 0 && !hold[k]) begin
          req_valid[k]         = 1'b1;
          req_data[16*k +: 16] = rq[k][0][15:0];
          req_last[k]          = rq[k][0][16];
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end
    end
  end

  // Lane monitor: every non-idle word is checked against the scoreboard.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; have_eof = 0; gap_run = 0; fill_cnt = 0; fr_pay = 0;
      end else if (ctrl == 2'b01 && data == 16'h50BC) begin
        if (in_frame) fill_cnt++;
        else gap_run++;
      end else begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got %h ctrl %b, required nothing", data, ctrl);
        end else begin
          e = exp_q.pop_front();
          if ({ctrl, data} !== e)
            begin
              fails++;
              $display("FAIL lane_word: got %h ctrl %b, required %h ctrl %b", data, ctrl, e[15:0], e[17:16]);
            end
        end
        if (ctrl == 2'b01 && data[7:0] == 8'hFB) begin
          if (have_eof) gap_q.push_back(gap_run);
          in_frame = 1; fill_cnt = 0; fr_pay = 0;
        end else if (ctrl == 2'b01 && data[7:0] == 8'hFD) begin
          in_frame = 0; have_eof = 1; gap_run = 0; last_fill = fill_cnt;
        end else if (ctrl == 2'b00) begin
          fr_pay++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_req(input int k, input logic [15:0] w, input logic last);
    rq[k].push_back({last, w});
  endtask

  task automatic exp_word(input logic [1:0] c, input logic [15:0] w);
    exp_q.push_back({c, w});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hold  = '0;
    for (int k = 0; k < 4; k++) rq[k].delete();
    exp_q.delete();
    gap_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= budget) begin
      fails++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), c);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({data, ctrl, req_ready, busy, grant} !== {16'h50BC, 2'b01, 4'b0, 1'b0, 2'b0}) begin
      fails++;
      $display("FAIL reset_hold: got data %h ctrl %b rdy %b busy %b grant %0d, required 50bc 01 0000 0 0",
               data, ctrl, req_ready, busy, grant);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({data, ctrl, req_ready, busy} !== {16'h50BC, 2'b01, 4'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset_idle: got data %h ctrl %b rdy %b busy %b, required 50bc 01 0000 0",
                 data, ctrl, req_ready, busy);
      end
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    push_req(0, 16'hA1A1, 1'b0);
    push_req(0, 16'hB2B2, 1'b0);
    push_req(0, 16'hC3C3, 1'b1);
    push_req(0, 16'hD4D4, 1'b1);
    exp_word(2'b01, 16'h00FB);
    exp_word(2'b00, 16'hA1A1);
    exp_word(2'b00, 16'hB2B2);
    exp_word(2'b00, 16'hC3C3);
    exp_word(2'b01, 16'h83FD);
    exp_word(2'b01, 16'h00FB);
    exp_word(2'b00, 16'hD4D4);
    exp_word(2'b01, 16'h81FD);
    wait_drain(100, "single");
    tests++;
    if (gap_q.size() != 1 || gap_q[0] != MIN_IDLE) begin
      fails++;
      $display("FAIL single_gap: got %0d gaps (first %0d), required 1 gap of %0d",
               gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, MIN_IDLE);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({data, ctrl, req_ready, busy} !== {16'h50BC, 2'b01, 4'b0, 1'b0}) begin
        fails++;
        $display("FAIL single_after: got data %h ctrl %b rdy %b busy %b, required 50bc 01 0000 0",
                 data, ctrl, req_ready, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_req(k, {4'(k), 4'(r), 8'h5A}, 1'b1);
        exp_word(2'b01, {8'(k), 8'hFB});
        exp_word(2'b00, {4'(k), 4'(r), 8'h5A});
        exp_word(2'b01, 16'h81FD);
      end
    end
    wait_drain(300, "rr");
    tests++;
    if (gap_q.size() != 7) begin
      fails++;
      $display("FAIL rr_gap_count: got %0d gaps, required 7", gap_q.size());
    end
    foreach (gap_q[i]) begin
      tests++;
      if (gap_q[i] != MIN_IDLE) begin
        fails++;
        $display("FAIL rr_gap: gap %0d got %0d idles, required %0d", i, gap_q[i], MIN_IDLE);
      end
    end
    tests++;
    if (grant !== 2'd3) begin
      fails++;
      $display("FAIL rr_last_grant: got %0d, required 3", grant);
    end
  endtask

  task automatic test_truncate();
    apply_reset();
    for (int i = 0; i < 20; i++) push_req(1, {8'h1C, 8'(i)}, (i == 19));
    push_req(2, 16'h2C00, 1'b0);
    push_req(2, 16'h2C01, 1'b1);
    exp_word(2'b01, 16'h01FB);
    for (int i = 0; i < 16; i++) exp_word(2'b00, {8'h1C, 8'(i)});
    exp_word(2'b01, 16'h10FD);
    exp_word(2'b01, 16'h02FB);
    exp_word(2'b00, 16'h2C00);
    exp_word(2'b00, 16'h2C01);
    exp_word(2'b01, 16'h82FD);
    exp_word(2'b01, 16'h01FB);
    for (int i = 16; i < 20; i++) exp_word(2'b00, {8'h1C, 8'(i)});
    exp_word(2'b01, 16'h84FD);
    wait_drain(300, "trunc");
    tests++;
    if (gap_q.size() != 2 || gap_q[0] != MIN_IDLE || gap_q[1] != MIN_IDLE) begin
      fails++;
      $display("FAIL trunc_gap: got %0d gaps, required 2 gaps of %0d", gap_q.size(), MIN_IDLE);
    end
  endtask

  task automatic test_stall_fill();
    int c = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) push_req(3, {8'h3C, 8'(i)}, (i == 4));
    exp_word(2'b01, 16'h03FB);
    for (int i = 0; i < 5; i++) exp_word(2'b00, {8'h3C, 8'(i)});
    exp_word(2'b01, 16'h85FD);
    while (!(in_frame && fr_pay >= 2) && c < 50) begin
      @(negedge clk);
      c++;
    end
    hold[3] = 1'b1;
    repeat (3) @(negedge clk);
    hold[3] = 1'b0;
    wait_drain(100, "stall");
    tests++;
    if (last_fill != 3) begin
      fails++;
      $display("FAIL stall_fill: got %0d fill words, required 3", last_fill);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) push_req(3, {8'h3D, 8'(i)}, (i == 9));
    exp_word(2'b01, 16'h03FB);
    for (int i = 0; i < 10; i++) exp_word(2'b00, {8'h3D, 8'(i)});
    exp_word(2'b01, 16'h8AFD);
    while (!(in_frame && fr_pay >= 3) && c < 50) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (!busy) begin
      fails++;
      $display("FAIL abort_busy: got busy %b before reset, required 1", busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rq[3].delete();
    exp_q.delete();
    tests++;
    if ({data, ctrl, req_ready, busy, grant} !== {16'h50BC, 2'b01, 4'b0, 1'b0, 2'b0}) begin
      fails++;
      $display("FAIL abort_async: got data %h ctrl %b rdy %b busy %b grant %0d, required 50bc 01 0000 0 0",
               data, ctrl, req_ready, busy, grant);
    end
    push_req(2, 16'h2E00, 1'b0);
    push_req(2, 16'h2E01, 1'b1);
    exp_word(2'b01, 16'h02FB);
    exp_word(2'b00, 16'h2E00);
    exp_word(2'b00, 16'h2E01);
    exp_word(2'b01, 16'h82FD);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_drain(100, "abort");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_truncate();
    test_stall_fill();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
